// File: rtl/avalon_mm_mem_slave_pkg.sv
// Shared Avalon-MM definitions: beat geometry helpers, error flag indices
// and the command opcode used by both the master and the memory slave.
package avalon_mm_pkg;

   typedef enum logic [1:0] {
      OP_NONE  = 2'd0,
      OP_READ  = 2'd1,
      OP_WRITE = 2'd2
   } op_e;

   // Bit positions inside err_flags.
   localparam int ERR_RANGE   = 0;
   localparam int ERR_RW_BOTH = 1;
   localparam int ERR_BURST   = 2;
   localparam int ERR_OVERRUN = 3;
   localparam int ERR_W       = 4;

   // Number of bytes carried by one data beat.
   function automatic int bytes_per_beat(input int beat_w);
      return beat_w / 8;
   endfunction

   // Number of low byte-address bits that select a byte within a beat.
   function automatic int byte_off_w(input int beat_w);
      return $clog2(beat_w / 8);
   endfunction

endpackage

// File: rtl/avalon_mm_mem_slave_if.sv
// Avalon-MM single-beat bus between a master (DMA) and a memory slave.
interface avalon_mm_mem_slave_if #(
   parameter int ADDR_W = 32,
   parameter int BEAT_W = 128
);
   logic [ADDR_W-1:0]   avs_address;
   logic                avs_read;
   logic                avs_write;
   logic [BEAT_W-1:0]   avs_writedata;
   logic [BEAT_W/8-1:0] avs_byteenable;
   logic [7:0]          avs_burstcount;
   logic [BEAT_W-1:0]   avs_readdata;
   logic                avs_readdatavalid;
   logic                avs_waitrequest;

   modport master (
      output avs_address, avs_read, avs_write, avs_writedata,
             avs_byteenable, avs_burstcount,
      input  avs_readdata, avs_readdatavalid, avs_waitrequest
   );

   modport slave (
      input  avs_address, avs_read, avs_write, avs_writedata,
             avs_byteenable, avs_burstcount,
      output avs_readdata, avs_readdatavalid, avs_waitrequest
   );
endinterface

// File: rtl/avalon_mm_mem_slave_rd_lat_pipe.sv
// Fixed-latency read return pipe: DEPTH stages of valid+data. Stage 0 is
// loaded on the accept edge; the last stage drives the bus. Data registers
// only move behind a valid, so the output holds the last returned word.
module avalon_rd_lat_pipe #(
   parameter int DATA_W = 128,
   parameter int DEPTH  = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_clear,
   input  logic              i_valid,
   input  logic [DATA_W-1:0] i_data,
   output logic              o_valid,
   output logic [DATA_W-1:0] o_data
);

   logic [DEPTH-1:0]  r_valid;
   logic [DATA_W-1:0] r_data [DEPTH];

   // Shift valids every cycle; clear drops everything in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= '0;
      end else begin
         // NOTE: non-blocking assignments let every stage sample the old
         // value of its predecessor, which is what makes this a shift register.
         r_valid[0] <= i_valid & ~i_clear;
         for (int s = 1; s < DEPTH; s++) begin
            r_valid[s] <= r_valid[s-1] & ~i_clear;
         end
      end
   end

   // Advance data only alongside a valid so idle stages keep their contents.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s < DEPTH; s++) begin
            r_data[s] <= '0;
         end
      end else begin
         if (i_valid) begin
            r_data[0] <= i_data;
         end
         for (int s = 1; s < DEPTH; s++) begin
            if (r_valid[s-1]) begin
               r_data[s] <= r_data[s-1];
            end
         end
      end
   end

   assign o_valid = r_valid[DEPTH-1];
   assign o_data  = r_data[DEPTH-1];

endmodule

// File: rtl/avalon_mm_mem_slave.sv
// Avalon-MM memory slave: word-addressed BEAT_W memory with byte-enabled
// writes, fixed-latency pipelined reads, an outstanding-read limit,
// injectable stalls, sticky protocol error flags and access counters.
module avalon_mm_mem_slave
   import avalon_mm_pkg::*;
#(
   parameter int BEAT_W          = 128,
   parameter int ADDR_W          = 32,
   parameter int MEM_DEPTH       = 256,
   parameter int RD_LAT          = 2,
   parameter int MAX_OUTSTANDING = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   avalon_mm_mem_slave_if.slave    bus,
   input  logic                    stall_inject,
   output logic [ERR_W-1:0]        err_flags,
   output logic [15:0]             rd_count,
   output logic [15:0]             wr_count
);

   localparam int BPB   = bytes_per_beat(BEAT_W);
   localparam int OFF_W = byte_off_w(BEAT_W);
   localparam int IDX_W = $clog2(MEM_DEPTH);
   localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1) + 1;
   localparam logic [OUT_W-1:0] OUT_MAX = OUT_W'(MAX_OUTSTANDING);

   logic [BEAT_W-1:0] r_mem [MEM_DEPTH];
   logic [OUT_W-1:0]  r_outstanding;
   logic [ERR_W-1:0]  r_err;
   logic [15:0]       r_rd_count;
   logic [15:0]       r_wr_count;

   logic [ADDR_W-1:0] w_word;
   logic [IDX_W-1:0]  w_idx;
   logic              w_in_range;
   logic              w_ret_now;
   logic              w_wait;
   op_e               w_op;
   logic              w_rd_acc;
   logic              w_wr_acc;
   logic [BEAT_W-1:0] w_rd_data;
   logic [ERR_W-1:0]  w_err_set;
   logic [BEAT_W-1:0] w_pipe_data;

   assign w_word     = bus.avs_address >> OFF_W;
   assign w_idx      = w_word[IDX_W-1:0];
   assign w_in_range = (w_word < ADDR_W'(MEM_DEPTH));

   // Decode the command, stall and error conditions for this cycle.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // leaves one unassigned and no latch is inferred.
      w_op      = OP_NONE;
      w_err_set = '0;
      w_wait    = ~rst_n | stall_inject |
                  (bus.avs_read & (r_outstanding == OUT_MAX) & ~w_ret_now);

      if (bus.avs_read & bus.avs_write) begin
         w_err_set[ERR_RW_BOTH] = 1'b1;
      end else if (bus.avs_read) begin
         w_op = OP_READ;
      end else if (bus.avs_write) begin
         w_op = OP_WRITE;
      end

      if (w_op != OP_NONE && !w_wait) begin
         w_err_set[ERR_RANGE] = ~w_in_range;
         w_err_set[ERR_BURST] = (bus.avs_burstcount != 8'd1);
      end

      w_err_set[ERR_OVERRUN] = (w_op == OP_READ) & ~w_wait & ~w_ret_now &
                               (r_outstanding >= OUT_MAX);
   end

   assign w_rd_acc  = (w_op == OP_READ)  & ~w_wait;
   assign w_wr_acc  = (w_op == OP_WRITE) & ~w_wait;
   assign w_rd_data = w_in_range ? r_mem[w_idx] : '0;

   // Byte-enabled memory write; out-of-range writes are dropped.
   always_ff @(posedge clk) begin
      // NOTE: the memory array is deliberately left out of reset; clearing it
      // would force flop-based storage and the contents carry no reset meaning.
      if (w_wr_acc && w_in_range) begin
         for (int b = 0; b < BPB; b++) begin
            if (bus.avs_byteenable[b]) begin
               r_mem[w_idx][b*8 +: 8] <= bus.avs_writedata[b*8 +: 8];
            end
         end
      end
   end

   avalon_rd_lat_pipe #(
      .DATA_W (BEAT_W),
      .DEPTH  (RD_LAT)
   ) u_rd_pipe (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_clear (1'b0),
      .i_valid (w_rd_acc),
      .i_data  (w_rd_data),
      .o_valid (w_ret_now),
      .o_data  (w_pipe_data)
   );

   // Track reads accepted but not yet returned.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_outstanding <= '0;
      end else begin
         case ({w_rd_acc, w_ret_now})
            2'b10:   r_outstanding <= r_outstanding + 1'b1;
            2'b01:   r_outstanding <= r_outstanding - 1'b1;
            default: r_outstanding <= r_outstanding;
         endcase
      end
   end

   // Sticky error flags and wrapping access counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_err      <= '0;
         r_rd_count <= '0;
         r_wr_count <= '0;
      end else begin
         r_err <= r_err | w_err_set;
         if (w_rd_acc) begin
            r_rd_count <= r_rd_count + 16'd1;
         end
         if (w_wr_acc) begin
            r_wr_count <= r_wr_count + 16'd1;
         end
      end
   end

   assign bus.avs_waitrequest   = w_wait;
   assign bus.avs_readdatavalid = w_ret_now;
   assign bus.avs_readdata      = w_pipe_data;
   assign err_flags             = r_err;
   assign rd_count              = r_rd_count;
   assign wr_count              = r_wr_count;

endmodule

// File: tb/tb_avalon_mm_mem_slave.sv
// Directed bench for avalon_mm_mem_slave. The main instance uses RD_LAT=2;
// a second instance with RD_LAT=3 covers outstanding-limit stalls and
// reset with reads in flight.
module tb_avalon_mm_mem_slave;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall, stall3;
   logic [3:0]  err, err3;
   logic [15:0] rdc, wrc, rdc3, wrc3;

   int n_pass   = 0;
   int n_checks = 0;

   avalon_mm_mem_slave_if #(.ADDR_W(32), .BEAT_W(128)) bus ();
   avalon_mm_mem_slave_if #(.ADDR_W(32), .BEAT_W(128)) bus3 ();

   avalon_mm_mem_slave #(
      .BEAT_W(128), .ADDR_W(32), .MEM_DEPTH(256), .RD_LAT(2), .MAX_OUTSTANDING(2)
   ) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus), .stall_inject(stall),
      .err_flags(err), .rd_count(rdc), .wr_count(wrc)
   );

   avalon_mm_mem_slave #(
      .BEAT_W(128), .ADDR_W(32), .MEM_DEPTH(256), .RD_LAT(3), .MAX_OUTSTANDING(2)
   ) dut3 (
      .clk(clk), .rst_n(rst_n), .bus(bus3), .stall_inject(stall3),
      .err_flags(err3), .rd_count(rdc3), .wr_count(wrc3)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   task automatic bus_write(input logic [31:0] addr, input logic [127:0] data,
                            input logic [15:0] be);
      int n;
      @(negedge clk);
      bus.avs_address    = addr;
      bus.avs_writedata  = data;
      bus.avs_byteenable = be;
      bus.avs_write      = 1'b1;
      n = 0;
      #1;
      while (bus.avs_waitrequest && n < 50) begin
         @(negedge clk); #1; n++;
      end
      @(posedge clk); #1;
      bus.avs_write = 1'b0;
   endtask

   task automatic bus_read(input logic [31:0] addr, output logic [127:0] data,
                           output int lat);
      int n;
      @(negedge clk);
      bus.avs_address = addr;
      bus.avs_read    = 1'b1;
      n = 0;
      #1;
      while (bus.avs_waitrequest && n < 50) begin
         @(negedge clk); #1; n++;
      end
      @(posedge clk); #1;
      bus.avs_read = 1'b0;
      lat = 1;
      while (!bus.avs_readdatavalid && lat < 20) begin
         @(posedge clk); #1; lat++;
      end
      data = bus.avs_readdata;
   endtask

   task automatic test_reset;
      n_checks++; if (bus.avs_waitrequest !== 1'b1) $display("FAIL rst_wait: got %b expected 1", bus.avs_waitrequest); else n_pass++;
      n_checks++; if (bus.avs_readdatavalid !== 1'b0) $display("FAIL rst_rdv: got %b expected 0", bus.avs_readdatavalid); else n_pass++;
      n_checks++; if (bus.avs_readdata !== 128'd0) $display("FAIL rst_rdata: got %h expected 0", bus.avs_readdata); else n_pass++;
      n_checks++; if (err !== 4'd0) $display("FAIL rst_err: got %b expected 0000", err); else n_pass++;
      n_checks++; if (rdc !== 16'd0 || wrc !== 16'd0) $display("FAIL rst_counts: got rd=%0d wr=%0d expected 0/0", rdc, wrc); else n_pass++;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      n_checks++; if (bus.avs_waitrequest !== 1'b0) $display("FAIL post_rst_wait: got %b expected 0", bus.avs_waitrequest); else n_pass++;
   endtask

   task automatic test_basic;
      logic [127:0] d;
      int lat;
      bus_write(32'h10, 128'h0F0E0D0C0B0A09080706050403020100, 16'hFFFF);
      bus_read(32'h10, d, lat);
      n_checks++; if (lat !== 2) $display("FAIL basic_latency: got %0d expected 2", lat); else n_pass++;
      n_checks++; if (d !== 128'h0F0E0D0C0B0A09080706050403020100) $display("FAIL basic_data: got %h expected 0f0e..0100", d); else n_pass++;
      n_checks++; if (wrc !== 16'd1 || rdc !== 16'd1) $display("FAIL basic_counts: got rd=%0d wr=%0d expected 1/1", rdc, wrc); else n_pass++;
      @(posedge clk); #1;
      n_checks++; if (bus.avs_readdatavalid !== 1'b0) $display("FAIL basic_single_pulse: got %b expected 0", bus.avs_readdatavalid); else n_pass++;
      n_checks++; if (bus.avs_readdata !== 128'h0F0E0D0C0B0A09080706050403020100) $display("FAIL basic_hold: got %h expected held data", bus.avs_readdata); else n_pass++;
   endtask

   task automatic test_byte_enable;
      logic [127:0] d;
      int lat;
      bus_write(32'h30, {128{1'b1}}, 16'hFFFF);
      bus_write(32'h30, 128'd0, 16'h00FF);
      bus_read(32'h30, d, lat);
      n_checks++; if (d !== 128'hFFFFFFFF_FFFFFFFF_00000000_00000000) $display("FAIL be_merge: got %h expected ffff..0000", d); else n_pass++;
      bus_read(32'h35, d, lat);
      n_checks++; if (d !== 128'hFFFFFFFF_FFFFFFFF_00000000_00000000) $display("FAIL be_offset_ignored: got %h expected ffff..0000", d); else n_pass++;
      n_checks++; if (wrc !== 16'd3 || rdc !== 16'd3) $display("FAIL be_counts: got rd=%0d wr=%0d expected 3/3", rdc, wrc); else n_pass++;
   endtask

   task automatic test_stall;
      logic [127:0] d;
      int lat;
      int n_wait;
      n_wait = 0;
      @(negedge clk);
      stall              = 1'b1;
      bus.avs_address    = 32'h20;
      bus.avs_writedata  = 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321;
      bus.avs_byteenable = 16'hFFFF;
      bus.avs_write      = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         if (bus.avs_waitrequest === 1'b1) n_wait++;
         @(negedge clk);
      end
      n_checks++; if (n_wait !== 5) $display("FAIL stall_wait_cycles: got %0d expected 5", n_wait); else n_pass++;
      n_checks++; if (wrc !== 16'd3) $display("FAIL stall_no_commit: got wr=%0d expected 3", wrc); else n_pass++;
      stall = 1'b0;
      #1;
      n_checks++; if (bus.avs_waitrequest !== 1'b0) $display("FAIL stall_release: got %b expected 0", bus.avs_waitrequest); else n_pass++;
      @(posedge clk); #1;
      bus.avs_write = 1'b0;
      @(negedge clk);
      n_checks++; if (wrc !== 16'd4) $display("FAIL stall_commit_once: got wr=%0d expected 4", wrc); else n_pass++;
      bus_read(32'h20, d, lat);
      n_checks++; if (d !== 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321) $display("FAIL stall_data: got %h expected 12345678..", d); else n_pass++;
   endtask

   task automatic test_back_to_back;
      logic [127:0] got [$];
      logic [6:0]   wait_vec;
      logic [11:0]  rdv_vec;
      int           n_acc;
      n_acc = 0;
      wait_vec = '0;
      rdv_vec  = '0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         bus3.avs_address   = 32'(i * 16);
         bus3.avs_writedata = {4{32'hA000_0000 | 32'(i)}};
         bus3.avs_write     = 1'b1;
      end
      @(negedge clk);
      bus3.avs_write = 1'b0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         bus3.avs_read    = (n_acc < 5);
         bus3.avs_address = 32'(n_acc * 16);
         #1;
         if (c < 7) wait_vec[c] = bus3.avs_waitrequest;
         rdv_vec[c] = bus3.avs_readdatavalid;
         if (bus3.avs_readdatavalid) got.push_back(bus3.avs_readdata);
         if (bus3.avs_read && !bus3.avs_waitrequest) n_acc++;
      end
      bus3.avs_read = 1'b0;
      n_checks++; if (wait_vec !== 7'b0100100) $display("FAIL b2b_wait_pattern: got %b expected 0100100 (cycle 0 is lsb)", wait_vec); else n_pass++;
      n_checks++; if (rdv_vec !== 12'b0010_1101_1000) $display("FAIL b2b_return_cycles: got %b expected 001011011000", rdv_vec); else n_pass++;
      n_checks++; if (got.size() !== 5) $display("FAIL b2b_return_count: got %0d expected 5", got.size()); else n_pass++;
      for (int i = 0; i < got.size() && i < 5; i++) begin
         n_checks++;
         if (got[i] !== {4{32'hA000_0000 | 32'(i)}}) $display("FAIL b2b_order_%0d: got %h expected %h", i, got[i], {4{32'hA000_0000 | 32'(i)}});
         else n_pass++;
      end
      n_checks++; if (err3 !== 4'd0) $display("FAIL b2b_no_err: got %b expected 0000", err3); else n_pass++;
      n_checks++; if (rdc3 !== 16'd5 || wrc3 !== 16'd5) $display("FAIL b2b_counts: got rd=%0d wr=%0d expected 5/5", rdc3, wrc3); else n_pass++;
   endtask

   task automatic test_errors;
      logic [127:0] d;
      int lat;
      bus_read(32'h1000, d, lat);
      n_checks++; if (d !== 128'd0) $display("FAIL err_oor_data: got %h expected 0", d); else n_pass++;
      n_checks++; if (err !== 4'b0001) $display("FAIL err_oor_flag: got %b expected 0001", err); else n_pass++;
      @(negedge clk);
      bus.avs_address = 32'h50;
      bus.avs_read    = 1'b1;
      bus.avs_write   = 1'b1;
      @(posedge clk); #1;
      bus.avs_read  = 1'b0;
      bus.avs_write = 1'b0;
      @(negedge clk);
      n_checks++; if (err !== 4'b0011) $display("FAIL err_rw_flag: got %b expected 0011", err); else n_pass++;
      n_checks++; if (rdc !== 16'd5 || wrc !== 16'd4) $display("FAIL err_rw_not_counted: got rd=%0d wr=%0d expected 5/4", rdc, wrc); else n_pass++;
      bus.avs_burstcount = 8'd4;
      bus_write(32'h40, 128'hCAFE_F00D_0000_1111_2222_3333_4444_5555, 16'hFFFF);
      bus.avs_burstcount = 8'd1;
      bus_read(32'h40, d, lat);
      n_checks++; if (d !== 128'hCAFE_F00D_0000_1111_2222_3333_4444_5555) $display("FAIL err_burst_single_beat: got %h expected cafef00d..", d); else n_pass++;
      n_checks++; if (err !== 4'b0111) $display("FAIL err_all_flags: got %b expected 0111", err); else n_pass++;
      n_checks++; if (wrc !== 16'd5 || rdc !== 16'd6) $display("FAIL err_counts: got rd=%0d wr=%0d expected 6/5", rdc, wrc); else n_pass++;
   endtask

   task automatic test_reset_midflight;
      int n_rdv;
      n_rdv = 0;
      @(negedge clk);
      bus3.avs_address = 32'h0;
      bus3.avs_read    = 1'b1;
      @(negedge clk);
      bus3.avs_address = 32'h10;
      @(negedge clk);
      bus3.avs_read = 1'b0;
      n_checks++; if (rdc3 !== 16'd7) $display("FAIL mid_reads_accepted: got rd=%0d expected 7", rdc3); else n_pass++;
      rst_n = 1'b0;
      #1;
      n_checks++; if (bus3.avs_waitrequest !== 1'b1 || bus.avs_waitrequest !== 1'b1) $display("FAIL mid_wait_in_reset: got %b/%b expected 1/1", bus3.avs_waitrequest, bus.avs_waitrequest); else n_pass++;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (bus3.avs_readdatavalid) n_rdv++;
      end
      n_checks++; if (n_rdv !== 0) $display("FAIL mid_no_return: got %0d pulses expected 0", n_rdv); else n_pass++;
      n_checks++; if (rdc3 !== 16'd0 || wrc3 !== 16'd0 || rdc !== 16'd0 || wrc !== 16'd0) $display("FAIL mid_counts_cleared: got %0d/%0d/%0d/%0d expected all 0", rdc3, wrc3, rdc, wrc); else n_pass++;
      n_checks++; if (err !== 4'd0 || err3 !== 4'd0) $display("FAIL mid_err_cleared: got %b/%b expected 0000/0000", err, err3); else n_pass++;
      n_checks++; if (bus3.avs_waitrequest !== 1'b0) $display("FAIL mid_wait_after: got %b expected 0", bus3.avs_waitrequest); else n_pass++;
   endtask

   initial begin
      rst_n  = 1'b0;
      stall  = 1'b0;
      stall3 = 1'b0;
      bus.avs_address     = '0;
      bus.avs_read        = 1'b0;
      bus.avs_write       = 1'b0;
      bus.avs_writedata   = '0;
      bus.avs_byteenable  = '1;
      bus.avs_burstcount  = 8'd1;
      bus3.avs_address    = '0;
      bus3.avs_read       = 1'b0;
      bus3.avs_write      = 1'b0;
      bus3.avs_writedata  = '0;
      bus3.avs_byteenable = '1;
      bus3.avs_burstcount = 8'd1;
      #3;
      test_reset();
      test_basic();
      test_byte_enable();
      test_stall();
      test_back_to_back();
      test_errors();
      test_reset_midflight();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/avalon_mm_mem_slave.md
Name: avalon_mm_mem_slave

Overview:
- Avalon-MM memory responder: the slave end of the interface driven by the DMA master.
- Holds a word-addressed BEAT_W-wide memory and services single-beat reads and writes.
- Read latency is fixed and configurable; reads are pipelined up to an outstanding limit, and waitrequest stalls can be injected.
- Serves as the DDR stand-in for block-level and system simulation, and as an on-chip scratch memory behind the interconnect.

Parameters:
- BEAT_W, 128: data width in bits; must be a multiple of 8.
- ADDR_W, 32: byte address width.
- MEM_DEPTH, 256: number of BEAT_W words; must be a power of 2.
- RD_LAT, 2: cycles from read acceptance to readdatavalid; must be >= 1.
- MAX_OUTSTANDING, 2: maximum number of accepted reads not yet returned; must be >= 1.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- avs_address  in  ADDR_W  byte address
- avs_read  in  1  read request
- avs_write  in  1  write request
- avs_writedata  in  BEAT_W  write data
- avs_byteenable  in  BEAT_W/8  per-byte write enable
- avs_burstcount  in  8  burst length; only 1 is supported
- avs_readdata  out  BEAT_W  read data
- avs_readdatavalid  out  1  read data valid
- avs_waitrequest  out  1  stall
- stall_inject  in  1  forces waitrequest while high (bench control)
- err_flags  out  4  sticky: [0] out of range, [1] read and write asserted together, [2] burstcount != 1, [3] readdatavalid overrun
- rd_count  out  16  accepted reads, wraps modulo 2^16
- wr_count  out  16  accepted writes, wraps modulo 2^16

Behaviour:
- Clock and reset: single clock `clk`; `rst_n` is asynchronous and active-low.
- Reset values:
  - readdatavalid 0, readdata 0, err_flags 0, rd_count 0, wr_count 0.
  - Pipeline valids cleared and outstanding count 0.
  - waitrequest is 1 while rst_n is low.
  - Memory contents are not reset.
- Reset mid-operation: all in-flight reads are discarded; no readdatavalid is produced after reset deasserts.
- Address decode:
  - word = avs_address >> log2(BEAT_W/8); the low byte-offset bits are ignored.
  - word >= MEM_DEPTH is out of range.
- Acceptance: a command is accepted on a rising edge where (avs_read | avs_write) = 1 and avs_waitrequest = 0.
- waitrequest is combinational:
  - waitrequest = stall_inject | (avs_read & (outstanding == MAX_OUTSTANDING) & !ret_now).
  - ret_now is the final pipeline stage valid this cycle.
  - Writes are never stalled by outstanding reads.
- Write:
  - At the accept edge, bytes with byteenable = 1 are updated; other bytes are preserved.
  - wr_count increments by 1.
  - Out-of-range write: dropped, err[0] set, still accepted and counted.
- Read:
  - At the accept edge, mem[word] is captured into pipeline stage 0.
  - readdatavalid is high in the cycle after edge k+RD_LAT-1, where k is the accept edge.
  - RD_LAT = 1 returns data in the cycle immediately after acceptance.
  - Out-of-range read returns all zeros and sets err[0].
  - rd_count increments by 1.
  - Exactly one readdatavalid pulse per accepted read, in acceptance order.
- Read-after-write: a write accepted at edge k is visible to a read accepted at edge k+1 or later.
- Outstanding count: +1 on read accept, -1 on return; both in the same cycle leaves it unchanged.
- Outside valid cycles: readdata holds its last returned value.
- avs_read and avs_write both high: neither operation is performed, waitrequest follows the rule above, err[1] is set, and the cycle is not counted.
- avs_burstcount != 1 on an accepted command: performed as a single beat, err[2] set.
- err[3]: internal assertion that the outstanding count went past MAX_OUTSTANDING; must never be set in a correct design.
- Error flags clear only on reset.

Decomposition:
- Shared package avalon_mm_pkg:
  - BYTES_PER_BEAT and byte-offset width functions.
  - err_flags bit index constants.
  - op_e enum (OP_NONE/OP_READ/OP_WRITE), reused by the master.
- Sub-module avalon_rd_lat_pipe: RD_LAT-deep valid+data shift register with a clear input.
- Top level contains the memory array, decode, waitrequest logic and counters.

Test Plan:
- Basic write/read:
  - Stimulus: write addr 0x10, data 0x00..0F pattern, byteenable all ones; then read addr 0x10 with RD_LAT = 2.
  - Response: readdatavalid exactly 2 cycles after acceptance with the same pattern; wr_count = 1, rd_count = 1.
- Byte enables:
  - Stimulus: write all-FF to word 3, then write 0 with byteenable 0x00FF.
  - Response: readback has the low 8 bytes 0 and the high 8 bytes FF.
- Back-to-back reads with MAX_OUTSTANDING = 2, RD_LAT = 3:
  - Stimulus: read requests held continuously.
  - Response: waitrequest rises on the third request and drops when the first return arrives; data returns in order; no err[3].
- Stall injection:
  - Stimulus: stall_inject high for 5 cycles while a write is pending.
  - Response: the write commits only after stall_inject drops; wr_count increments once.
- Errors:
  - Stimulus: read addr 0x1000 (word 256); assert read and write together; send burstcount 4.
  - Response: read returns 0; err_flags = 4'b0111.
- Reset mid-flight:
  - Stimulus: 2 reads accepted, then rst_n pulsed low.
  - Response: no readdatavalid after release; counters 0; waitrequest 1 during reset.
